fetch_pc_unit: RTL and testbench

Fetch-stage consumer of the branch-resolution outputs (PC_sel, flush). It owns the program counter and selects the next PC from the sequential address, branch target, JAL target or JALR target. It drives the instruction-memory request handshake and the IF/ID pipeline register. Redirects squash the wrong-path instruction by inserting a NOP bubble. A one-entry skid buffer absorbs instructions that return while decode is stalled.

---
 rtl/fetch_pc_unit_pkg.sv | 12 +
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_pc_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch/branch-resolution definitions: next-PC select codes and
// the bubble instruction inserted on squash.
package fetch_pc_unit_pkg;

   localparam logic [1:0] PC_SEQ  = 2'b00;
   localparam logic [1:0] PC_BR   = 2'b01;
   localparam logic [1:0] PC_JAL  = 2'b10;
   localparam logic [1:0] PC_JALR = 2'b11;

   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer for instructions that return
// while decode is stalled.
module fetch_skid_buf #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic            clear,
   input  logic [XLEN-1:0] wr_pc,
   input  logic [31:0]     wr_instr,
   output logic [XLEN-1:0] rd_pc,
   output logic [31:0]     rd_instr,
   output logic            full
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         full     <= 1'b0;
         rd_pc    <= '0;
         rd_instr <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (push) begin
         full     <= 1'b1;
         rd_pc    <= wr_pc;
         rd_instr <= wr_instr;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, drives the imem request handshake and the
// IF/ID register, and squashes wrong-path fetches on redirect.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [31:0] NOP_INSTR = NOP
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      PC_sel,
   input  logic            flush,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jal_target,
   input  logic [XLEN-1:0] jalr_target,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic [XLEN-1:0] IF_ID_pc,
   output logic [31:0]     IF_ID_instr,
   output logic            IF_ID_valid,
   output logic            fetch_busy
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_KILL  = 2'd2
   } state_e;

   state_e          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] tgt;
   logic            pending;
   logic            run;

   logic [XLEN-1:0] sel_tgt;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] seq_pc;
   logic            redirect;
   logic            xfer;
   logic            keep;

   logic            sk_push;
   logic            sk_pop;
   logic            sk_full;
   logic [XLEN-1:0] sk_pc;
   logic [31:0]     sk_instr;

   always_comb begin
      sel_tgt = pc;
      unique case (PC_sel)
         PC_BR:   sel_tgt = branch_target;
         PC_JAL:  sel_tgt = jal_target;
         PC_JALR: sel_tgt = jalr_target;
         default: sel_tgt = pc;
      endcase
   end

   assign target   = sel_tgt & ~XLEN'(3);
   assign seq_pc   = pc + XLEN'(4);
   assign redirect = flush & (PC_sel != PC_SEQ);

   // A full skid while in FETCH means decode is backed up: hold off
   // issuing. In WAIT/KILL a request is already out and must stay up.
   assign imem_req   = run & ~((state == ST_FETCH) & sk_full);
   assign imem_addr  = pc;
   assign xfer       = imem_req & imem_ready;
   assign keep       = xfer & ~redirect & (state != ST_KILL);
   assign fetch_busy = (state != ST_FETCH) | pending;

   assign sk_push = ~flush & stall & keep;
   assign sk_pop  = ~flush & ~stall & sk_full;

   fetch_skid_buf #(
      .XLEN(XLEN)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (sk_push),
      .pop      (sk_pop),
      .clear    (flush),
      .wr_pc    (pc),
      .wr_instr (imem_rdata),
      .rd_pc    (sk_pc),
      .rd_instr (sk_instr),
      .full     (sk_full)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_FETCH;
         pc      <= RESET_PC;
         tgt     <= RESET_PC;
         pending <= 1'b0;
         run     <= 1'b0;
      end else begin
         run <= 1'b1;
         unique case (state)
            ST_FETCH, ST_WAIT: begin
               if (redirect) begin
                  if (xfer || !imem_req) begin
                     pc    <= target;
                     state <= ST_FETCH;
                  end else begin
                     tgt     <= target;
                     pending <= 1'b1;
                     state   <= ST_KILL;
                  end
               end else if (xfer) begin
                  pc    <= seq_pc;
                  state <= ST_FETCH;
               end else if (imem_req) begin
                  state <= ST_WAIT;
               end else begin
                  state <= ST_FETCH;
               end
            end
            ST_KILL: begin
               if (xfer) begin
                  pc      <= redirect ? target : tgt;
                  pending <= 1'b0;
                  state   <= ST_FETCH;
               end else if (redirect) begin
                  tgt <= target;
               end
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         IF_ID_pc    <= '0;
         IF_ID_instr <= NOP_INSTR;
         IF_ID_valid <= 1'b0;
      end else if (flush) begin
         IF_ID_instr <= NOP_INSTR;
         IF_ID_valid <= 1'b0;
      end else if (stall) begin
         IF_ID_valid <= IF_ID_valid;
      end else if (sk_full) begin
         IF_ID_pc    <= sk_pc;
         IF_ID_instr <= sk_instr;
         IF_ID_valid <= 1'b1;
      end else if (keep) begin
         IF_ID_pc    <= pc;
         IF_ID_instr <= imem_rdata;
         IF_ID_valid <= 1'b1;
      end else begin
         IF_ID_instr <= NOP_INSTR;
         IF_ID_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; imem returns ~addr as the instruction.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst_n;
   logic [1:0]  PC_sel;
   logic        flush;
   logic [31:0] branch_target;
   logic [31:0] jal_target;
   logic [31:0] jalr_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] IF_ID_pc;
   logic [31:0] IF_ID_instr;
   logic        IF_ID_valid;
   logic        fetch_busy;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOPI = 32'h0000_0013;

   fetch_pc_unit dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .PC_sel        (PC_sel),
      .flush         (flush),
      .branch_target (branch_target),
      .jal_target    (jal_target),
      .jalr_target   (jalr_target),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .IF_ID_pc      (IF_ID_pc),
      .IF_ID_instr   (IF_ID_instr),
      .IF_ID_valid   (IF_ID_valid),
      .fetch_busy    (fetch_busy)
   );

   assign imem_rdata = ~imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; stall = 1'b0; PC_sel = 2'b00;
      imem_ready = 1'b0;
      branch_target = '0; jal_target = '0; jalr_target = '0;
      step(); step();
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL rst_req: got %b exp 0", imem_req);
      end
      checks++;
      if (imem_addr !== 32'h0) begin
         errors++; $display("FAIL rst_addr: got %h exp 0", imem_addr);
      end
      checks++;
      if (IF_ID_valid !== 1'b0) begin
         errors++; $display("FAIL rst_valid: got %b exp 0", IF_ID_valid);
      end
      checks++;
      if (IF_ID_instr !== NOPI) begin
         errors++; $display("FAIL rst_instr: got %h exp %h", IF_ID_instr, NOPI);
      end
      checks++;
      if (IF_ID_pc !== 32'h0) begin
         errors++; $display("FAIL rst_pc: got %h exp 0", IF_ID_pc);
      end
      checks++;
      if (fetch_busy !== 1'b0) begin
         errors++; $display("FAIL rst_busy: got %b exp 0", fetch_busy);
      end
   endtask

   task automatic test_seq();
      rst_n = 1'b1;
      imem_ready = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
            errors++;
            $display("FAIL seq_addr%0d: got req=%b addr=%h exp req=1 addr=%h",
                     i, imem_req, imem_addr, 32'(4 * i));
         end
         step();
         checks++;
         if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'(4 * i) ||
             IF_ID_instr !== ~32'(4 * i)) begin
            errors++;
            $display("FAIL seq_ifid%0d: got v=%b pc=%h ins=%h exp v=1 pc=%h ins=%h",
                     i, IF_ID_valid, IF_ID_pc, IF_ID_instr,
                     32'(4 * i), ~32'(4 * i));
         end
      end
   endtask

   task automatic test_branch_flush();
      checks++;
      if (imem_addr !== 32'h10) begin
         errors++; $display("FAIL br_pre_addr: got %h exp 10", imem_addr);
      end
      flush = 1'b1; PC_sel = 2'b01; branch_target = 32'h100;
      step();
      flush = 1'b0; PC_sel = 2'b00;
      checks++;
      if (IF_ID_valid !== 1'b0 || IF_ID_instr !== NOPI) begin
         errors++;
         $display("FAIL br_bubble: got v=%b ins=%h exp v=0 ins=%h",
                  IF_ID_valid, IF_ID_instr, NOPI);
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         errors++;
         $display("FAIL br_addr: got req=%b addr=%h exp req=1 addr=100",
                  imem_req, imem_addr);
      end
      step();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h100 ||
          IF_ID_instr !== ~32'h100) begin
         errors++;
         $display("FAIL br_ifid: got v=%b pc=%h ins=%h exp v=1 pc=100 ins=%h",
                  IF_ID_valid, IF_ID_pc, IF_ID_instr, ~32'h100);
      end
   endtask

   task automatic test_jalr_kill();
      flush = 1'b1; PC_sel = 2'b10; jal_target = 32'h20;
      step();
      imem_ready = 1'b0; PC_sel = 2'b11; jalr_target = 32'h203;
      step();
      flush = 1'b0; PC_sel = 2'b00;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h20 || fetch_busy !== 1'b1) begin
            errors++;
            $display("FAIL kill_hold%0d: got req=%b addr=%h busy=%b exp 1/20/1",
                     i, imem_req, imem_addr, fetch_busy);
         end
         if (i < 2) step();
      end
      imem_ready = 1'b1;
      step();
      checks++;
      if (IF_ID_valid !== 1'b0 || imem_addr !== 32'h200 || fetch_busy !== 1'b0) begin
         errors++;
         $display("FAIL kill_done: got v=%b addr=%h busy=%b exp 0/200/0",
                  IF_ID_valid, imem_addr, fetch_busy);
      end
      step();
      checks++;
      if (IF_ID_valid !== 1'b1 || IF_ID_pc !== 32'h200) begin
         errors++;
         $display("FAIL kill_ifid: got v=%b pc=%h exp v=1 pc=200",
                  IF_ID_valid, IF_ID_pc);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      step();
      checks++;
      if (IF_ID_pc !== 32'h200 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL stall1: got pc=%h req=%b exp pc=200 req=0",
                  IF_ID_pc, imem_req);
      end
      step();
      checks++;
      if (IF_ID_pc !== 32'h200 || IF_ID_valid !== 1'b1 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL stall2: got pc=%h v=%b req=%b exp pc=200 v=1 req=0",
                  IF_ID_pc, IF_ID_valid, imem_req);
      end
      stall = 1'b0;
      step();
      checks++;
      if (IF_ID_pc !== 32'h204 || IF_ID_instr !== ~32'h204 ||
          IF_ID_valid !== 1'b1 || imem_addr !== 32'h208) begin
         errors++;
         $display("FAIL stall_skid: got pc=%h ins=%h v=%b addr=%h exp 204/%h/1/208",
                  IF_ID_pc, IF_ID_instr, IF_ID_valid, imem_addr, ~32'h204);
      end
      step();
      checks++;
      if (IF_ID_pc !== 32'h208 || IF_ID_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_resume: got pc=%h v=%b exp pc=208 v=1",
                  IF_ID_pc, IF_ID_valid);
      end
   endtask

   task automatic test_wrap();
      flush = 1'b1; PC_sel = 2'b10; jal_target = 32'hFFFF_FFFC;
      step();
      flush = 1'b0; PC_sel = 2'b00;
      checks++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_pre: got %h exp fffffffc", imem_addr);
      end
      step();
      checks++;
      if (imem_addr !== 32'h0 || IF_ID_pc !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap: got addr=%h ifpc=%h exp addr=0 ifpc=fffffffc",
                  imem_addr, IF_ID_pc);
      end
   endtask

   task automatic test_reset_kill();
      imem_ready = 1'b0; flush = 1'b1; PC_sel = 2'b01;
      branch_target = 32'h300;
      step();
      flush = 1'b0; PC_sel = 2'b00;
      checks++;
      if (fetch_busy !== 1'b1) begin
         errors++; $display("FAIL rk_busy: got %b exp 1", fetch_busy);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if (imem_req !== 1'b0 || IF_ID_valid !== 1'b0 ||
          fetch_busy !== 1'b0 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL rk_reset: got req=%b v=%b busy=%b addr=%h exp 0/0/0/0",
                  imem_req, IF_ID_valid, fetch_busy, imem_addr);
      end
      rst_n = 1'b1; imem_ready = 1'b1;
      PC_sel = 2'b01; branch_target = 32'h500;
      step();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         errors++;
         $display("FAIL rk_restart: got req=%b addr=%h exp req=1 addr=0",
                  imem_req, imem_addr);
      end
      step();
      checks++;
      if (IF_ID_pc !== 32'h0 || IF_ID_valid !== 1'b1 || imem_addr !== 32'h4) begin
         errors++;
         $display("FAIL rk_noflush_sel: got pc=%h v=%b addr=%h exp 0/1/4",
                  IF_ID_pc, IF_ID_valid, imem_addr);
      end
      PC_sel = 2'b00;
   endtask

   initial begin
      test_reset();
      test_seq();
      test_branch_flush();
      test_jalr_kill();
      test_stall();
      test_wrap();
      test_reset_kill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
